// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline register: slice record and depth limit.
// The record is sized for the widest legal datapath; unused upper bits stay zero.
package mem_wb_pkg;

    localparam int unsigned DEPTH_MAX  = 4;
    localparam int unsigned DATA_W_MAX = 64;
    localparam int unsigned ADDR_W_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W_MAX-1:0] data;
        logic                  regwrite;
        logic [ADDR_W_MAX-1:0] addr;
    } slice_t;

endpackage

// File: rtl/wb_slice.sv
// One MEM/WB register slice with stall hold and flush invalidation.
module wb_slice
    import mem_wb_pkg::*;
(
    input  logic   clk2,
    input  logic   rst_n,
    input  logic   stall_i,
    input  logic   flush_i,
    input  slice_t slice_i,
    output slice_t slice_o
);

    slice_t slice_d, slice_q;

    // Flush only drops the valid bit; payload is left untouched so it stays stable.
    always_comb begin
        slice_d = slice_q;
        if (flush_i) begin
            slice_d.valid = 1'b0;
        end else if (!stall_i) begin
            slice_d = slice_i;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            slice_q <= '0;
        end else begin
            slice_q <= slice_d;
        end
    end

    assign slice_o = slice_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of DEPTH slices with write-back select and forwarding.
// Forwarding compare logic is built only when MEM_WB_FWD_EN is defined.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 1
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              MemToReg,
    input  logic              L3_Regwrite,
    input  logic [ADDR_W-1:0] L3_regwradd,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] regwradd,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
);

    slice_t slice_in [DEPTH];
    slice_t slice_q  [DEPTH];
    logic [DEPTH-1:0] unused_slice;

    // Write-back data is muxed once at capture so only one copy is stored.
    always_comb begin
        slice_in[0]          = '0;
        slice_in[0].valid    = in_valid;
        slice_in[0].data     = DATA_W_MAX'(MemToReg ? mem_out : alu_out);
        slice_in[0].regwrite = L3_Regwrite;
        slice_in[0].addr     = ADDR_W_MAX'(L3_regwradd);
        for (int k = 1; k < int'(DEPTH); k++) begin
            slice_in[k] = slice_q[k-1];
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : gen_slice
        wb_slice u_slice (
            .clk2    (clk2),
            .rst_n   (rst_n),
            .stall_i (stall),
            .flush_i (flush),
            .slice_i (slice_in[k]),
            .slice_o (slice_q[k])
        );
        assign unused_slice[k] = ^slice_q[k];
    end

    assign out_valid = slice_q[DEPTH-1].valid;
    assign wb_data   = slice_q[DEPTH-1].data[DATA_W-1:0];
    assign RegWrite  = slice_q[DEPTH-1].valid & slice_q[DEPTH-1].regwrite;
    assign regwradd  = slice_q[DEPTH-1].addr[ADDR_W-1:0];

`ifdef MEM_WB_FWD_EN
    // Scan oldest to youngest so the youngest matching slice overrides.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (slice_q[k].valid && slice_q[k].regwrite &&
                slice_q[k].addr[ADDR_W-1:0] == src_a) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = slice_q[k].data[DATA_W-1:0];
            end
            if (slice_q[k].valid && slice_q[k].regwrite &&
                slice_q[k].addr[ADDR_W-1:0] == src_b) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = slice_q[k].data[DATA_W-1:0];
            end
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{src_a, src_b};
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: three instances (DEPTH 1, 2, 3) share one stimulus.
module tb_mem_wb_stage;

`ifdef MEM_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] alu_out = '0, mem_out = '0;
    logic       MemToReg = 1'b0, L3_Regwrite = 1'b0;
    logic [2:0] L3_regwradd = '0;
    logic       stall = 1'b0, flush = 1'b0;
    logic [2:0] src_a = '0, src_b = '0;

    logic       ov1, rw1, ha1, hb1, ov2, rw2, ha2, hb2, ov3, rw3, ha3, hb3;
    logic [7:0] wd1, fa1, fb1, wd2, fa2, fb2, wd3, fa3, fb3;
    logic [2:0] ra1, ra2, ra3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk2 = ~clk2;

    mem_wb_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(1)) dut1 (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .alu_out(alu_out), .mem_out(mem_out),
        .MemToReg(MemToReg), .L3_Regwrite(L3_Regwrite), .L3_regwradd(L3_regwradd),
        .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
        .out_valid(ov1), .wb_data(wd1), .RegWrite(rw1), .regwradd(ra1),
        .fwd_a_hit(ha1), .fwd_b_hit(hb1), .fwd_a_data(fa1), .fwd_b_data(fb1)
    );

    mem_wb_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut2 (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .alu_out(alu_out), .mem_out(mem_out),
        .MemToReg(MemToReg), .L3_Regwrite(L3_Regwrite), .L3_regwradd(L3_regwradd),
        .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
        .out_valid(ov2), .wb_data(wd2), .RegWrite(rw2), .regwradd(ra2),
        .fwd_a_hit(ha2), .fwd_b_hit(hb2), .fwd_a_data(fa2), .fwd_b_data(fb2)
    );

    mem_wb_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(3)) dut3 (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .alu_out(alu_out), .mem_out(mem_out),
        .MemToReg(MemToReg), .L3_Regwrite(L3_Regwrite), .L3_regwradd(L3_regwradd),
        .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
        .out_valid(ov3), .wb_data(wd3), .RegWrite(rw3), .regwradd(ra3),
        .fwd_a_hit(ha3), .fwd_b_hit(hb3), .fwd_a_data(fa3), .fwd_b_data(fb3)
    );

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    // Reset asserted and released mid-cycle, away from any clock edge.
    task automatic do_reset();
        tick();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [7:0] alu, input logic [7:0] mem,
                         input logic m2r, input logic rw, input logic [2:0] addr);
        in_valid = v; alu_out = alu; mem_out = mem; MemToReg = m2r;
        L3_Regwrite = rw; L3_regwradd = addr;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({ov1, rw1, wd1, ra1} !== 13'd0) begin
            $display("FAIL reset_d1 got {ov,rw,wd,ra}=%b %b %h %h want 0", ov1, rw1, wd1, ra1);
            miscompares++;
        end
        vectors++;
        if ({ov3, rw3, wd3, ra3, ha3, hb3, fa3, fb3} !== 31'd0) begin
            $display("FAIL reset_d3 got ov=%b rw=%b wd=%h ra=%h fwd=%b%b %h %h want 0",
                     ov3, rw3, wd3, ra3, ha3, hb3, fa3, fb3);
            miscompares++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_capture();
        do_reset();
        drive(1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1, 3'd5);
        tick();
        vectors++;
        if ({ov1, rw1, wd1, ra1} !== {1'b1, 1'b1, 8'hA5, 3'd5}) begin
            $display("FAIL capture_mem got ov=%b rw=%b wd=%h ra=%0d want 1 1 a5 5",
                     ov1, rw1, wd1, ra1);
            miscompares++;
        end
        drive(1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1, 3'd6);
        tick();
        vectors++;
        if ({rw1, wd1, ra1} !== {1'b1, 8'h3C, 3'd6}) begin
            $display("FAIL capture_alu got rw=%b wd=%h ra=%0d want 1 3c 6", rw1, wd1, ra1);
            miscompares++;
        end
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 3'd1);
        tick();
        vectors++;
        if ({ov1, rw1} !== 2'b10) begin
            $display("FAIL capture_norw got ov=%b rw=%b want 1 0", ov1, rw1);
            miscompares++;
        end
        drive(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, 3'd1);
        tick();
        vectors++;
        if ({ov1, rw1} !== 2'b00) begin
            $display("FAIL capture_invalid got ov=%b rw=%b want 0 0", ov1, rw1);
            miscompares++;
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 3'd3);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        vectors++;
        if ({ov1, ov2, ov3} !== 3'b100) begin
            $display("FAIL latency_e1 got ov1/2/3=%b%b%b want 100", ov1, ov2, ov3);
            miscompares++;
        end
        tick();
        vectors++;
        if ({ov1, ov2, ov3} !== 3'b010) begin
            $display("FAIL latency_e2 got ov1/2/3=%b%b%b want 010", ov1, ov2, ov3);
            miscompares++;
        end
        tick();
        vectors++;
        if ({ov3, rw3, wd3, ra3, ov2} !== {1'b1, 1'b1, 8'h77, 3'd3, 1'b0}) begin
            $display("FAIL latency_e3 got ov3=%b rw3=%b wd3=%h ra3=%0d ov2=%b want 1 1 77 3 0",
                     ov3, rw3, wd3, ra3, ov2);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 3'd3);
        tick();
        stall = 1'b1;
        drive(1'b1, 8'h99, 8'h00, 1'b0, 1'b1, 3'd4);
        tick();
        tick();
        vectors++;
        if ({ov1, wd1, ra1, ov3} !== {1'b1, 8'h77, 3'd3, 1'b0}) begin
            $display("FAIL stall_hold got ov1=%b wd1=%h ra1=%0d ov3=%b want 1 77 3 0",
                     ov1, wd1, ra1, ov3);
            miscompares++;
        end
        stall = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        tick();
        vectors++;
        if ({ov1, ov2, ov3} !== 3'b010) begin
            $display("FAIL stall_e4 got ov1/2/3=%b%b%b want 010", ov1, ov2, ov3);
            miscompares++;
        end
        tick();
        vectors++;
        if ({ov3, wd3, ra3} !== {1'b1, 8'h77, 3'd3}) begin
            $display("FAIL stall_e5 got ov3=%b wd3=%h ra3=%0d want 1 77 3", ov3, wd3, ra3);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 3'd1);
        tick();
        drive(1'b1, 8'h22, 8'h00, 1'b0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 8'h33, 8'h00, 1'b0, 1'b1, 3'd3);
        tick();
        vectors++;
        if ({ov3, rw3, wd3, ra3} !== {1'b1, 1'b1, 8'h11, 3'd1}) begin
            $display("FAIL flush_pre got ov3=%b rw3=%b wd3=%h ra3=%0d want 1 1 11 1",
                     ov3, rw3, wd3, ra3);
            miscompares++;
        end
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 8'h44, 8'h00, 1'b0, 1'b1, 3'd4);
        tick();
        vectors++;
        if ({ov3, rw3, wd3, ra3, ov1, rw1, wd1} !== {2'b00, 8'h11, 3'd1, 2'b00, 8'h33}) begin
            $display("FAIL flush_edge got ov3=%b rw3=%b wd3=%h ra3=%0d ov1=%b rw1=%b wd1=%h want 0 0 11 1 0 0 33",
                     ov3, rw3, wd3, ra3, ov1, rw1, wd1);
            miscompares++;
        end
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ov3, rw3, ov2, rw2} !== 4'b0000) begin
                $display("FAIL flush_drain%0d got ov3=%b rw3=%b ov2=%b rw2=%b want 0 0 0 0",
                         i, ov3, rw3, ov2, rw2);
                miscompares++;
            end
        end
    endtask

    task automatic test_forward();
        do_reset();
        drive(1'b1, 8'h22, 8'h00, 1'b0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 3'd2);
        tick();
        stall = 1'b1;
        src_a = 3'd2; src_b = 3'd4;
        #1;
        vectors++;
        if ({ha2, fa2} !== {FWD, FWD ? 8'h11 : 8'h00}) begin
            $display("FAIL fwd_young_a got hit=%b data=%h want %b %h",
                     ha2, fa2, FWD, FWD ? 8'h11 : 8'h00);
            miscompares++;
        end
        vectors++;
        if ({hb2, fb2} !== 9'd0) begin
            $display("FAIL fwd_miss_b got hit=%b data=%h want 0 00", hb2, fb2);
            miscompares++;
        end
        stall = 1'b0;
        drive(1'b1, 8'h44, 8'h00, 1'b0, 1'b0, 3'd4);
        tick();
        vectors++;
        if ({ha2, fa2, hb2, fb2} !== {FWD, FWD ? 8'h11 : 8'h00, 9'd0}) begin
            $display("FAIL fwd_old_norw got a=%b/%h b=%b/%h want %b/%h 0/00",
                     ha2, fa2, hb2, fb2, FWD, FWD ? 8'h11 : 8'h00);
            miscompares++;
        end
        vectors++;
        if ({ha1, fa1} !== 9'd0) begin
            $display("FAIL fwd_d1_nomatch got hit=%b data=%h want 0 00", ha1, fa1);
            miscompares++;
        end
        drive(1'b0, 8'h55, 8'h00, 1'b0, 1'b1, 3'd4);
        tick();
        vectors++;
        if ({hb1, fb1} !== 9'd0) begin
            $display("FAIL fwd_invalid got hit=%b data=%h want 0 00", hb1, fb1);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 8'h5A, 8'h00, 1'b0, 1'b1, 3'd7);
        tick();
        tick();
        tick();
        stall = 1'b1; flush = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ov1, rw1, wd1, ra1, ov3, rw3, wd3, ra3} !== 26'd0) begin
            $display("FAIL async_reset got d1=%b%b/%h/%0d d3=%b%b/%h/%0d want all 0",
                     ov1, rw1, wd1, ra1, ov3, rw3, wd3, ra3);
            miscompares++;
        end
        vectors++;
        if ({ha3, fa3} !== 9'd0) begin
            $display("FAIL async_reset_fwd got hit=%b data=%h want 0 00", ha3, fa3);
            miscompares++;
        end
        #1;
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 8'h6B, 8'h00, 1'b0, 1'b1, 3'd6);
        tick();
        vectors++;
        if ({ov1, rw1, wd1, ra1, ov3} !== {2'b11, 8'h6B, 3'd6, 1'b0}) begin
            $display("FAIL reset_first_capture got ov1=%b rw1=%b wd1=%h ra1=%0d ov3=%b want 1 1 6b 6 0",
                     ov1, rw1, wd1, ra1, ov3);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_latency();
        test_stall();
        test_flush();
        test_forward();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
